divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential restoring divider that pairs with the team's shift-add multiplier: computes quotient and remainder of an unsigned 8-bit dividend by an unsigned 4-bit divisor, one quotient bit per clock.
- Uses the same board flow: switches supply the operands, active-low push buttons i_load and i_start drive it, and 7-segment displays (active-low segments) show the operands and the results.
- Sits at the top level of the board lab design beside the multiplier.

Parameters:
- N_W, 8, dividend and quotient width. Fixed; do not override.
- D_W, 4, divisor and remainder width. Fixed; do not override.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_load  in  1  active-low button; latches the operands in IDLE.
- i_start  in  1  active-low button; starts the calculation, then returns the block to IDLE from FINISH.
- i_N  in  8  dividend from the switches.
- i_D  in  4  divisor from the switches.
- o_done  out  1  high while in FINISH.
- o_Q  out  8  quotient.
- o_R  out  4  remainder.
- o_div_zero  out  1  divide-by-zero flag (DIV_ZERO_FLAG_EN only; tied 0 otherwise).
- seg_i_N_hundred, seg_i_N_ten, seg_i_N_unit  out  7 each  dividend digits.
- seg_i_D_ten, seg_i_D_unit  out  7 each  divisor digits.
- seg_o_Q_hundred, seg_o_Q_ten, seg_o_Q_unit  out  7 each  quotient digits.
- seg_o_R_ten, seg_o_R_unit  out  7 each  remainder digits.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE; all internal registers 0; o_done=0, o_Q=0, o_R=0, o_div_zero=0. Every seg display then shows "0" (7'b1000000).
- States: IDLE, LOAD, CALC, FINISH.
- IDLE:
  - Each cycle clears the work registers, o_done, o_Q, o_R and o_div_zero.
  - If i_load==0: latch i_N into the dividend shift register (n_reg) and the display register; latch i_D into the divisor and display registers; go to LOAD.
- LOAD:
  - Holds the latched values; further i_load presses and switch changes are ignored.
  - If i_start==0, go to CALC.
- CALC:
  - Does nothing while i_start==0, so the press that caused the entry does not advance the calculation.
  - On each cycle with i_start==1 and idx<8:
    - t = {r[3:0], n_reg[7]} (5 bits); n_reg <<= 1.
    - If t >= divisor: r = t - divisor and n_reg[0]=1; else r = t and n_reg[0]=0.
    - idx += 1.
  - On the cycle with idx==8: o_Q<=n_reg, o_R<=r[3:0], o_done<=1, idx<=0, go to FINISH.
  - Latency: o_done rises on the 9th qualifying edge after i_start is released.
- FINISH:
  - o_done=1; o_Q and o_R are held.
  - If i_start==0, go to IDLE; o_done falls one cycle later.
- Width rules:
  - r < divisor always holds, so t <= 29 and fits 5 bits.
  - o_Q max is 255, o_R max is 14.
- Divisor = 0 without the macro: every compare passes, so o_Q=8'hFF and o_R is the low 4 bits of the natural algorithm result. This is not flagged.
- Reset mid-CALC: immediate return to the reset values.
- Simultaneous presses: i_start is ignored in IDLE and i_load is ignored in all other states.
- 7-seg encoding:
  - Decimal digits via /10, /100 and %10.
  - Codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Dash = 0111111; any other value shows 0.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - In CALC, if the divisor is 0, skip the iterations. On the first i_start==1 cycle go directly to FINISH with o_Q=0, o_R=0, o_div_zero=1, o_done=1.
  - While o_div_zero=1, all five quotient/remainder displays show a dash.
  - o_div_zero clears in IDLE.
- Undefined: no detection; o_div_zero tied 0; divisor 0 follows the natural algorithm path.

Test Plan:
- Load N=200, D=7, start -> after 9 edges o_done=1, o_Q=28, o_R=4; seg_o_Q shows 0/2/8, seg_o_R shows 0/4.
- Load N=255, D=1, then N=5, D=9 -> o_Q=255/o_R=0, then o_Q=0/o_R=5; start pressed in FINISH returns to IDLE with o_done=0.
- Hold i_start low for 5 cycles in CALC -> idx stays 0; o_done still requires 9 edges after release.
- Change switches and press i_load in LOAD -> latched operands and displays remain unchanged.
- Assert i_rst at idx=4 of 12/5 -> outputs 0 and state IDLE immediately; a new load of 12/5 gives o_Q=2, o_R=2.
- D=0, N=77 -> with DIV_ZERO_FLAG_EN: o_div_zero=1, o_Q=0, dashes shown; without it: o_Q=255, o_div_zero=0.

Source files
------------

// File: rtl/divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | divider : 8-bit / 4-bit sequential restoring divider, one quotient bit   |
// |           per clock, with active-low 7-segment operand/result displays.  |
// | Optional macro DIV_ZERO_FLAG_EN: flag divide-by-zero, skip iterations.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module divider #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_start,
  input  logic [N_W-1:0] i_N,
  input  logic [D_W-1:0] i_D,
  output logic           o_done,
  output logic [N_W-1:0] o_Q,
  output logic [D_W-1:0] o_R,
  output logic           o_div_zero,
  output logic [6:0]     seg_i_N_hundred,
  output logic [6:0]     seg_i_N_ten,
  output logic [6:0]     seg_i_N_unit,
  output logic [6:0]     seg_i_D_ten,
  output logic [6:0]     seg_i_D_unit,
  output logic [6:0]     seg_o_Q_hundred,
  output logic [6:0]     seg_o_Q_ten,
  output logic [6:0]     seg_o_Q_unit,
  output logic [6:0]     seg_o_R_ten,
  output logic [6:0]     seg_o_R_unit
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CALC   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] c_ITER     = 4'd8;
  localparam logic [6:0] c_SEG_DASH = 7'b0111111;

  state_t     r_state, w_state_nx;
  logic [7:0] r_n, w_n_nx;
  logic [3:0] r_rem, w_rem_nx;
  logic [3:0] r_div, w_div_nx;
  logic [7:0] r_disp_n, w_disp_n_nx;
  logic [3:0] r_disp_d, w_disp_d_nx;
  logic [3:0] r_idx, w_idx_nx;
  logic       r_done, w_done_nx;
  logic [7:0] r_q, w_q_nx;
  logic [3:0] r_r, w_r_nx;
  logic       r_dz, w_dz_nx;

  // One restoring step: shift the next dividend bit into the partial remainder.
  logic [4:0] w_t;
  logic       w_ge;
  logic [3:0] w_diff;
  assign w_t    = {r_rem, r_n[7]};
  assign w_ge   = (w_t >= {1'b0, r_div});
  assign w_diff = w_t[3:0] - r_div;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_disp_n <= '0;
      r_disp_d <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
      r_dz     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_n      <= w_n_nx;
      r_rem    <= w_rem_nx;
      r_div    <= w_div_nx;
      r_disp_n <= w_disp_n_nx;
      r_disp_d <= w_disp_d_nx;
      r_idx    <= w_idx_nx;
      r_done   <= w_done_nx;
      r_q      <= w_q_nx;
      r_r      <= w_r_nx;
      r_dz     <= w_dz_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_n_nx      = r_n;
    w_rem_nx    = r_rem;
    w_div_nx    = r_div;
    w_disp_n_nx = r_disp_n;
    w_disp_d_nx = r_disp_d;
    w_idx_nx    = r_idx;
    w_done_nx   = r_done;
    w_q_nx      = r_q;
    w_r_nx      = r_r;
    w_dz_nx     = r_dz;
    case (r_state)
      S_IDLE: begin
        w_n_nx    = '0;
        w_rem_nx  = '0;
        w_idx_nx  = '0;
        w_done_nx = 1'b0;
        w_q_nx    = '0;
        w_r_nx    = '0;
        w_dz_nx   = 1'b0;
        if (!i_load) begin
          w_n_nx      = i_N;
          w_div_nx    = i_D;
          w_disp_n_nx = i_N;
          w_disp_d_nx = i_D;
          w_state_nx  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!i_start) w_state_nx = S_CALC;
      end
      S_CALC: begin
        // The start press that entered CALC is still held; wait for release.
        if (i_start) begin
`ifdef DIV_ZERO_FLAG_EN
          if (r_div == 4'd0) begin
            w_q_nx     = '0;
            w_r_nx     = '0;
            w_dz_nx    = 1'b1;
            w_done_nx  = 1'b1;
            w_idx_nx   = '0;
            w_state_nx = S_FINISH;
          end else
`endif
          if (r_idx < c_ITER) begin
            w_rem_nx = w_ge ? w_diff : w_t[3:0];
            w_n_nx   = {r_n[6:0], w_ge};
            w_idx_nx = r_idx + 4'd1;
          end else begin
            w_q_nx     = r_n;
            w_r_nx     = r_rem;
            w_done_nx  = 1'b1;
            w_idx_nx   = '0;
            w_state_nx = S_FINISH;
          end
        end
      end
      S_FINISH: begin
        if (!i_start) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign o_done     = r_done;
  assign o_Q        = r_q;
  assign o_R        = r_r;
  assign o_div_zero = r_dz;

  function automatic logic [6:0] f_seg(input logic [7:0] v);
    case (v)
      8'd0:    f_seg = 7'b1000000;
      8'd1:    f_seg = 7'b1111001;
      8'd2:    f_seg = 7'b0100100;
      8'd3:    f_seg = 7'b0110000;
      8'd4:    f_seg = 7'b0011001;
      8'd5:    f_seg = 7'b0010010;
      8'd6:    f_seg = 7'b0000010;
      8'd7:    f_seg = 7'b1111000;
      8'd8:    f_seg = 7'b0000000;
      8'd9:    f_seg = 7'b0010000;
      default: f_seg = 7'b1000000;
    endcase
  endfunction

  assign seg_i_N_hundred = f_seg(r_disp_n / 8'd100);
  assign seg_i_N_ten     = f_seg((r_disp_n / 8'd10) % 8'd10);
  assign seg_i_N_unit    = f_seg(r_disp_n % 8'd10);
  assign seg_i_D_ten     = f_seg({4'd0, r_disp_d / 4'd10});
  assign seg_i_D_unit    = f_seg({4'd0, r_disp_d % 4'd10});

  // Result digits show dashes while divide-by-zero is flagged.
  assign seg_o_Q_hundred = r_dz ? c_SEG_DASH : f_seg(r_q / 8'd100);
  assign seg_o_Q_ten     = r_dz ? c_SEG_DASH : f_seg((r_q / 8'd10) % 8'd10);
  assign seg_o_Q_unit    = r_dz ? c_SEG_DASH : f_seg(r_q % 8'd10);
  assign seg_o_R_ten     = r_dz ? c_SEG_DASH : f_seg({4'd0, r_r / 4'd10});
  assign seg_o_R_unit    = r_dz ? c_SEG_DASH : f_seg({4'd0, r_r % 4'd10});

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_divider : self-checking bench for divider (directed + random cases).  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_divider;

  logic       i_clk = 1'b0;
  logic       i_rst, i_load, i_start;
  logic [7:0] i_N;
  logic [3:0] i_D;
  logic       o_done, o_div_zero;
  logic [7:0] o_Q;
  logic [3:0] o_R;
  logic [6:0] seg_i_N_hundred, seg_i_N_ten, seg_i_N_unit, seg_i_D_ten, seg_i_D_unit;
  logic [6:0] seg_o_Q_hundred, seg_o_Q_ten, seg_o_Q_unit, seg_o_R_ten, seg_o_R_unit;

  divider dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_load(i_load), .i_start(i_start),
    .i_N(i_N), .i_D(i_D), .o_done(o_done), .o_Q(o_Q), .o_R(o_R),
    .o_div_zero(o_div_zero),
    .seg_i_N_hundred(seg_i_N_hundred), .seg_i_N_ten(seg_i_N_ten), .seg_i_N_unit(seg_i_N_unit),
    .seg_i_D_ten(seg_i_D_ten), .seg_i_D_unit(seg_i_D_unit),
    .seg_o_Q_hundred(seg_o_Q_hundred), .seg_o_Q_ten(seg_o_Q_ten), .seg_o_Q_unit(seg_o_Q_unit),
    .seg_o_R_ten(seg_o_R_ten), .seg_o_R_unit(seg_o_R_unit)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [6:0] SEG_TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  int tests = 0;
  int fails = 0;

  function automatic logic [6:0] seg_of(input int v);
    return (v >= 0 && v <= 9) ? SEG_TBL[v] : SEG_TBL[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] n, input logic [3:0] d);
    i_N = n; i_D = d; i_load = 1'b0;
    step();
    i_load = 1'b1;
  endtask

  // Press start (LOAD->CALC), optionally hold it, release and count edges to done.
  task automatic run_calc(input int hold, output int lat);
    i_start = 1'b0;
    step();
    repeat (hold) step();
    i_start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic verify_run(input string tag, input int n, input int d, input int hold);
    int eq, er, el, lat;
    logic dz;
    dz = 1'b0;
    if (d == 0) begin
`ifdef DIV_ZERO_FLAG_EN
      eq = 0; er = 0; el = 1; dz = 1'b1;
`else
      eq = 255; er = n % 16; el = 9;
`endif
    end else begin
      eq = n / d; er = n % d; el = 9;
    end
    run_calc(hold, lat);
    chk({tag, ":latency"}, lat, el);
    chk({tag, ":Q"}, {24'd0, o_Q}, eq);
    chk({tag, ":R"}, {28'd0, o_R}, er);
    chk({tag, ":div_zero"}, {31'd0, o_div_zero}, {31'd0, dz});
    chk({tag, ":segNh"}, seg_i_N_hundred, seg_of(n / 100));
    chk({tag, ":segNt"}, seg_i_N_ten, seg_of((n / 10) % 10));
    chk({tag, ":segNu"}, seg_i_N_unit, seg_of(n % 10));
    chk({tag, ":segDt"}, seg_i_D_ten, seg_of(d / 10));
    chk({tag, ":segDu"}, seg_i_D_unit, seg_of(d % 10));
    chk({tag, ":segQh"}, seg_o_Q_hundred, dz ? SEG_DASH : seg_of(eq / 100));
    chk({tag, ":segQt"}, seg_o_Q_ten, dz ? SEG_DASH : seg_of((eq / 10) % 10));
    chk({tag, ":segQu"}, seg_o_Q_unit, dz ? SEG_DASH : seg_of(eq % 10));
    chk({tag, ":segRt"}, seg_o_R_ten, dz ? SEG_DASH : seg_of(er / 10));
    chk({tag, ":segRu"}, seg_o_R_unit, dz ? SEG_DASH : seg_of(er % 10));
    // Return to IDLE: done stays high one more cycle, then clears.
    i_start = 1'b0;
    step();
    chk({tag, ":done_hold"}, {31'd0, o_done}, 32'd1);
    i_start = 1'b1;
    step();
    chk({tag, ":done_clear"}, {31'd0, o_done}, 32'd0);
    chk({tag, ":Q_clear"}, {24'd0, o_Q}, 32'd0);
    chk({tag, ":dz_clear"}, {31'd0, o_div_zero}, 32'd0);
  endtask

  initial begin
    int n, d;
    i_rst = 1'b1; i_load = 1'b1; i_start = 1'b1; i_N = '0; i_D = '0;
    step(); step();
    chk("reset:done", {31'd0, o_done}, 32'd0);
    chk("reset:Q", {24'd0, o_Q}, 32'd0);
    chk("reset:R", {28'd0, o_R}, 32'd0);
    chk("reset:div_zero", {31'd0, o_div_zero}, 32'd0);
    chk("reset:segQu", seg_o_Q_unit, 32'b1000000);
    chk("reset:segNh", seg_i_N_hundred, 32'b1000000);
    i_rst = 1'b0;
    step();

    // 200/7 = 28 r 4, digits checked against the literal segment codes.
    do_load(8'd200, 4'd7);
    verify_run("200/7", 200, 7, 0);
    do_load(8'd200, 4'd7);
    begin
      int lat;
      run_calc(0, lat);
      chk("200/7b:segQh", seg_o_Q_hundred, 32'b1000000);
      chk("200/7b:segQt", seg_o_Q_ten, 32'b0100100);
      chk("200/7b:segQu", seg_o_Q_unit, 32'b0000000);
      chk("200/7b:segRu", seg_o_R_unit, 32'b0011001);
      i_start = 1'b0; step(); i_start = 1'b1; step();
    end

    do_load(8'd255, 4'd1);
    verify_run("255/1", 255, 1, 0);
    do_load(8'd5, 4'd9);
    verify_run("5/9", 5, 9, 0);
    do_load(8'd0, 4'd15);
    verify_run("0/15", 0, 15, 0);
    do_load(8'd255, 4'd15);
    verify_run("255/15", 255, 15, 0);

    // Start held low in CALC must not advance the iterations.
    do_load(8'd131, 4'd6);
    verify_run("hold5", 131, 6, 5);

    // Switch changes and a second load press in LOAD are ignored.
    do_load(8'd100, 4'd3);
    i_N = 8'd250; i_D = 4'd11; i_load = 1'b0;
    step(); step();
    i_load = 1'b1;
    chk("loadlock:segNh", seg_i_N_hundred, seg_of(1));
    chk("loadlock:segDu", seg_i_D_unit, seg_of(3));
    verify_run("loadlock", 100, 3, 0);

    // Both buttons in IDLE: only the load takes effect.
    i_N = 8'd77; i_D = 4'd4; i_load = 1'b0; i_start = 1'b0;
    step();
    i_load = 1'b1; i_start = 1'b1;
    verify_run("both", 77, 4, 0);

    // Asynchronous reset in the middle of a calculation.
    do_load(8'd12, 4'd5);
    i_start = 1'b0; step();
    i_start = 1'b1;
    repeat (4) step();
    #2 i_rst = 1'b1;
    #1;
    chk("midrst:done", {31'd0, o_done}, 32'd0);
    chk("midrst:Q", {24'd0, o_Q}, 32'd0);
    chk("midrst:segNu", seg_i_N_unit, seg_of(0));
    chk("midrst:segDu", seg_i_D_unit, seg_of(0));
    step();
    i_rst = 1'b0;
    step();
    do_load(8'd12, 4'd5);
    verify_run("12/5", 12, 5, 0);

    // Divide by zero.
    do_load(8'd77, 4'd0);
    verify_run("77/0", 77, 0, 0);

    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(0, 255));
      d = int'($urandom_range(1, 15));
      do_load(n[7:0], d[3:0]);
      verify_run($sformatf("rnd%0d_%0d/%0d", i, n, d), n, d, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
